// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/stall sequencer for the 5-stage pipeline
// Optional perf counters (stall_cnt, flush_cnt) enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 32
`ifdef PIPE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mdu_start,
  input  logic             ex_branch_tkn,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             bubble_idex,
  output logic             bubble_memwb,
  output logic             mdu_busy
`ifdef PIPE_CTRL_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int MB = $clog2(MDU_LAT);

  typedef enum logic [0:0] {RUN, MDU_WAIT} state_t;

  state_t        state, state_next;
  logic [MB-1:0] mdu_cnt, mdu_cnt_next;

  logic mem_stall;
  logic load_use;
  logic mdu_freeze;
  logic mdu_release;

  assign mem_stall   = mem_access & ~mem_ready;
  assign load_use    = ex_is_load & (ex_rd != '0) &
                       ((id_uses_rs & (id_rs == ex_rd)) |
                        (id_uses_rt & (id_rt == ex_rd)));
  assign mdu_freeze  = ((state == RUN) & ex_mdu_start) |
                       ((state == MDU_WAIT) & (mdu_cnt != '0));
  assign mdu_release = (state == MDU_WAIT) & (mdu_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else begin
      state   <= state_next;
      mdu_cnt <= mdu_cnt_next;
    end
  end

  // The MDU runs on its own, so the countdown continues through memory stalls;
  // only the start and the release wait for the pipeline to be free to move.
  always_comb begin
    state_next   = state;
    mdu_cnt_next = mdu_cnt;
    case (state)
      RUN: begin
        if (ex_mdu_start & ~mem_stall) begin
          mdu_cnt_next = MB'(MDU_LAT - 1);
          state_next   = MDU_WAIT;
        end
      end
      MDU_WAIT: begin
        if (mdu_cnt != '0)
          mdu_cnt_next = mdu_cnt - MB'(1);
        else if (~mem_stall)
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    en_pc        = 1'b1;
    en_ifid      = 1'b1;
    en_idex      = 1'b1;
    en_exmem     = 1'b1;
    en_memwb     = 1'b1;
    flush_ifid   = 1'b0;
    bubble_idex  = 1'b0;
    bubble_memwb = 1'b0;
    mdu_busy     = 1'b0;
    if (rst) begin
      en_pc        = 1'b0;
      en_ifid      = 1'b0;
      en_idex      = 1'b0;
      en_exmem     = 1'b0;
      en_memwb     = 1'b0;
      flush_ifid   = 1'b1;
      bubble_idex  = 1'b1;
      bubble_memwb = 1'b1;
    end else if (mem_stall) begin
      en_pc    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
    end else if (mdu_freeze) begin
      en_pc        = 1'b0;
      en_ifid      = 1'b0;
      en_idex      = 1'b0;
      en_exmem     = 1'b0;
      bubble_memwb = 1'b1;
      mdu_busy     = 1'b1;
    end else if (mdu_release) begin
      // EX still holds the finishing MDU op: let it drain with no hazard action.
      en_pc = 1'b1;
    end else if (ex_branch_tkn) begin
      flush_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (load_use) begin
      en_pc       = 1'b0;
      en_ifid     = 1'b0;
      bubble_idex = 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (~en_pc & ~(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ifid & ~(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
